mac_seq_ctrl: RTL and testbench



---
 rtl/mac_seq_ctrl.sv | 87 ++++++++
 tb/tb_mac_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences dot-product jobs through one fixed-point MAC and returns the result
module mac_seq_ctrl #(
  parameter int MULTIPLIER_CYCLE = 6,
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [4:0]           cfg_shift,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_a,
  input  logic [15:0]          in_b,
  output logic [15:0]          mac_operand_a,
  output logic [15:0]          mac_operand_b,
  output logic                 mac_clk_en,
  output logic                 mac_start,
  output logic                 mac_stop,
  output logic [4:0]           mac_shift,
  input  logic [15:0]          mac_out,
  input  logic                 mac_output_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_data,
  output logic                 busy
);
  localparam int FW = $clog2(MULTIPLIER_CYCLE + 2);
  typedef enum logic [2:0] {FLUSH, IDLE, CLEAR, STREAM, DRAIN, HOLD} state_t;
  state_t r_state, w_next;
  logic [FW-1:0] r_flush;
  logic [LEN_WIDTH-1:0] r_beats;
  logic w_cfg_hs, w_in_hs, w_last, w_flush_done, w_capture;
  assign w_cfg_hs = cfg_valid & cfg_ready;
  assign w_in_hs = in_valid & in_ready;
  assign w_last = r_beats == LEN_WIDTH'(1);
  assign w_flush_done = r_flush == FW'(MULTIPLIER_CYCLE);
  assign w_capture = (r_state == DRAIN) & mac_output_valid;
  // state register; reset lands in FLUSH so stale MAC pipeline contents drain out
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FLUSH;
    else r_state <= w_next;
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      FLUSH:  w_next = w_flush_done ? IDLE : FLUSH;
      IDLE:   w_next = cfg_valid ? (cfg_len != '0 ? CLEAR : HOLD) : IDLE;
      CLEAR:  w_next = STREAM;
      STREAM: w_next = (w_in_hs & w_last) ? DRAIN : STREAM;
      DRAIN:  w_next = mac_output_valid ? HOLD : DRAIN;
      HOLD:   w_next = res_ready ? IDLE : HOLD;
      default: w_next = FLUSH;
    endcase
  end
  // handshake and status outputs decoded from the current state
  always_comb begin
    cfg_ready = r_state == IDLE;
    in_ready = r_state == STREAM;
    res_valid = r_state == HOLD;
    busy = r_state != IDLE;
  end
  // counters, registered MAC framing and result capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_flush <= '0;
      r_beats <= '0;
      mac_operand_a <= '0;
      mac_operand_b <= '0;
      mac_clk_en <= 1'b0;
      mac_start <= 1'b0;
      mac_stop <= 1'b0;
      mac_shift <= '0;
      res_data <= '0;
    end else begin
      r_flush <= r_state == FLUSH ? r_flush + 1'b1 : '0;
      r_beats <= w_cfg_hs ? cfg_len : w_in_hs ? r_beats - 1'b1 : r_beats;
      mac_operand_a <= w_in_hs ? in_a : '0;
      mac_operand_b <= w_in_hs ? in_b : '0;
      mac_clk_en <= w_in_hs;
      mac_start <= w_cfg_hs & (cfg_len != '0);
      mac_stop <= w_in_hs & w_last;
      mac_shift <= w_cfg_hs ? cfg_shift : mac_shift;
      res_data <= w_cfg_hs ? '0 : w_capture ? mac_out : res_data;
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed scoreboard bench for mac_seq_ctrl with a behavioural MAC model
module tb_mac_seq_ctrl;
  localparam int MC = 6;
  localparam int LW = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [LW-1:0] cfg_len = '0;
  logic [4:0] cfg_shift = '0;
  logic in_valid = 1'b0, in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic [15:0] mac_operand_a, mac_operand_b, mac_out, res_data;
  logic mac_clk_en, mac_start, mac_stop, mac_output_valid;
  logic [4:0] mac_shift;
  logic res_valid, res_ready = 1'b0, busy;
  logic stale = 1'b0;
  int checks = 0, errors = 0;
  int en_cnt = 0, start_cnt = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.MULTIPLIER_CYCLE(MC), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_operand_a(mac_operand_a), .mac_operand_b(mac_operand_b), .mac_clk_en(mac_clk_en),
    .mac_start(mac_start), .mac_stop(mac_stop), .mac_shift(mac_shift), .mac_out(mac_out),
    .mac_output_valid(mac_output_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy));

  // MAC model: unresettable accumulator, valid pulse MC cycles after the stop beat
  logic signed [39:0] acc = '0;
  logic signed [39:0] sh;
  logic signed [31:0] prod;
  logic [MC-1:0] vsr = '0;
  assign prod = $signed(mac_operand_a) * $signed(mac_operand_b);
  assign sh = acc >>> mac_shift;
  assign mac_out = {sh[39], sh[14:0]};
  assign mac_output_valid = vsr[MC-1] | stale;
  always @(posedge clk) begin
    if (mac_start) acc <= '0;
    else if (mac_clk_en) acc <= acc + {{8{prod[31]}}, prod};
    vsr <= {vsr[MC-2:0], mac_clk_en & mac_stop};
    if (mac_clk_en) en_cnt <= en_cnt + 1;
    if (mac_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [LW-1:0] len, input logic [4:0] shift, input logic [15:0] exp);
    chk("cfg_ready_before_job", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_len = len;
    cfg_shift = shift;
    sb.push_back(exp);
    tick;
    cfg_valid = 1'b0;
    chk("mac_start", mac_start, len != 0);
    chk("mac_shift_latched", mac_shift, shift);
    if (len != 0) begin
      tick;
      chk("mac_start_one_cycle", mac_start, 0);
      chk("in_ready_stream", in_ready, 1);
    end
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input bit last, input bit gap);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    chk("beat_clk_en", mac_clk_en, 1);
    chk("beat_op_a", mac_operand_a, a);
    chk("beat_op_b", mac_operand_b, b);
    chk("beat_stop", mac_stop, last);
    if (last) chk("in_ready_drain", in_ready, 0);
    if (gap) begin
      tick;
      chk("gap_clk_en", mac_clk_en, 0);
      chk("gap_op_a", mac_operand_a, 0);
    end
  endtask

  task automatic finish_job(input int exp_lat, input int hold, input logic [4:0] shift);
    int n = 1;
    while (!res_valid && n < 100) begin
      tick;
      n++;
    end
    chk("res_latency", n, exp_lat);
    chk("mac_shift_held", mac_shift, shift);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, sb[0]);
      chk("hold_cfg_ready", cfg_ready, 0);
    end
    res_ready = 1'b1;
    chk("res_data", res_data, sb.pop_front());
    tick;
    res_ready = 1'b0;
    chk("res_valid_clear", res_valid, 0);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, e0, s0;
    tick;
    tick;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_mac", {mac_operand_a, mac_operand_b, mac_clk_en, mac_start, mac_stop, mac_shift}, 0);
    rst = 1'b0;
    n = 0;
    do begin tick; n++; end while (!cfg_ready && n < 50);
    chk("flush_cycles", n, MC + 1);
    // len=4 back-to-back, then held 5 cycles in HOLD
    start_job(12'd4, 5'd0, 16'h0046);
    beat(16'd1, 16'd5, 0, 0);
    beat(16'd2, 16'd6, 0, 0);
    beat(16'd3, 16'd7, 0, 0);
    beat(16'd4, 16'd8, 1, 0);
    finish_job(MC + 2, 5, 5'd0);
    // second job must see a cleared accumulator
    start_job(12'd2, 5'd0, 16'h0002);
    beat(16'd1, 16'd1, 0, 0);
    beat(16'd1, 16'd1, 1, 0);
    finish_job(MC + 2, 0, 5'd0);
    // output shift
    start_job(12'd1, 5'd8, 16'h0200);
    beat(16'h0100, 16'h0200, 1, 0);
    finish_job(MC + 2, 1, 5'd8);
    // negative operands with in_valid gaps
    e0 = en_cnt;
    start_job(12'd3, 5'd0, 16'hFFEE);
    beat(16'hFFFE, 16'd3, 0, 1);
    beat(16'hFFFE, 16'd3, 0, 1);
    beat(16'hFFFE, 16'd3, 1, 0);
    finish_job(MC + 2, 0, 5'd0);
    chk("gap_job_clk_en_count", en_cnt - e0, 3);
    // zero-length job
    e0 = en_cnt;
    s0 = start_cnt;
    start_job(12'd0, 5'd3, 16'h0000);
    finish_job(1, 2, 5'd3);
    chk("len0_no_clk_en", en_cnt - e0, 0);
    chk("len0_no_start", start_cnt - s0, 0);
    // abort mid-stream after 2 of 4 beats
    cfg_valid = 1'b1;
    cfg_len = 12'd4;
    cfg_shift = 5'd2;
    tick;
    cfg_valid = 1'b0;
    tick;
    beat(16'd7, 16'd7, 0, 0);
    beat(16'd7, 16'd7, 0, 0);
    rst = 1'b1;
    #1;
    chk("abort_cfg_ready", cfg_ready, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_res", {res_valid, res_data}, 0);
    chk("abort_busy", busy, 1);
    chk("abort_mac", {mac_operand_a, mac_operand_b, mac_clk_en, mac_start, mac_stop, mac_shift}, 0);
    stale = 1'b1;
    tick;
    rst = 1'b0;
    n = 0;
    do begin tick; n++; end while (!cfg_ready && n < 50);
    chk("abort_flush_cycles", n, MC + 1);
    tick;
    chk("stale_ignored_res_valid", res_valid, 0);
    chk("stale_ignored_res_data", res_data, 0);
    chk("stale_ignored_busy", busy, 0);
    stale = 1'b0;
    start_job(12'd2, 5'd0, 16'h0012);
    beat(16'd3, 16'd3, 0, 0);
    beat(16'd3, 16'd3, 1, 0);
    finish_job(MC + 2, 0, 5'd0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
